// File: rtl/rv_iopmp_entry_bram_adapter_pkg.sv
// Shared types and helpers for the IOPMP entry BRAM adapter.
// Contents: adapter FSM state enum, line-geometry helper functions.
package rv_iopmp_entry_bram_adapter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_HIT      = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_ERR      = 3'd5
  } bram_adapter_state_e;

  // Number of register-side words held in one BRAM line.
  function automatic int words_per_line(input int bram_dw, input int out_dw);
    return bram_dw / out_dw;
  endfunction

  function automatic logic is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/rv_iopmp_entry_bram_adapter_if.sv
// Register-side request/response bundle of the entry BRAM adapter.
// master: regmap side (drives requests and flush); slave: adapter side.
// Signals: req_valid/req_ready handshake, req_we, req_addr {entry,word},
// req_wdata, req_be, rsp_valid pulse, rsp_rdata, rsp_err, flush.
interface rv_iopmp_entry_bram_adapter_if #(
  parameter int AW        = 5,
  parameter int OUT_WIDTH = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [AW-1:0]          req_addr;
  logic [OUT_WIDTH-1:0]   req_wdata;
  logic [OUT_WIDTH/8-1:0] req_be;
  logic                   rsp_valid;
  logic [OUT_WIDTH-1:0]   rsp_rdata;
  logic                   rsp_err;
  logic                   flush;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, flush,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, flush,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv_iopmp_entry_bram_adapter_line_buf.sv
// One-line read buffer for the entry BRAM adapter.
// Holds a full BRAM line with its entry tag and valid bit, applies
// byte-enabled write-through when a write targets the buffered entry,
// and returns the selected word combinationally.
// Ports: clk_i/rst_i, flush_i (clears valid), wr_* (write-through),
// fill_* (load a line from BRAM), rd_word_i -> rd_data_o, valid_o, tag_o.
module rv_iopmp_line_buf #(
  parameter int BRAM_DWIDTH = 128,
  parameter int OUT_WIDTH   = 32,
  parameter int EW          = 3,
  parameter int WW          = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   wr_en_i,
  input  logic [EW-1:0]          wr_tag_i,
  input  logic [WW-1:0]          wr_word_i,
  input  logic [OUT_WIDTH-1:0]   wr_data_i,
  input  logic [OUT_WIDTH/8-1:0] wr_be_i,
  input  logic                   fill_en_i,
  input  logic                   fill_valid_i,
  input  logic [EW-1:0]          fill_tag_i,
  input  logic [BRAM_DWIDTH-1:0] fill_data_i,
  input  logic [WW-1:0]          rd_word_i,
  output logic                   valid_o,
  output logic [EW-1:0]          tag_o,
  output logic [OUT_WIDTH-1:0]   rd_data_o
);
  localparam int OB    = OUT_WIDTH / 8;
  localparam int WORDS = BRAM_DWIDTH / OUT_WIDTH;

  logic [BRAM_DWIDTH-1:0] line_q, line_d;
  logic [EW-1:0]          tag_q, tag_d;
  logic                   valid_q, valid_d;
  int                     wr_idx_s;
  int                     rd_idx_s;

  // Masking keeps the word index inside the line even when WORDS == 1.
  assign wr_idx_s  = int'(wr_word_i) & (WORDS - 1);
  assign rd_idx_s  = int'(rd_word_i) & (WORDS - 1);
  assign rd_data_o = line_q[rd_idx_s*OUT_WIDTH +: OUT_WIDTH];
  assign valid_o   = valid_q;
  assign tag_o     = tag_q;

  // Next line contents: fill beats write-through; flush always drops valid.
  always_comb begin
    line_d  = line_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (fill_en_i) begin
      line_d  = fill_data_i;
      tag_d   = fill_tag_i;
      valid_d = fill_valid_i;
    end else if (wr_en_i && valid_q && (tag_q == wr_tag_i)) begin
      for (int b = 0; b < OB; b++) begin
        line_d[(wr_idx_s*OB + b)*8 +: 8] = wr_be_i[b] ? wr_data_i[b*8 +: 8]
                                                      : line_q[(wr_idx_s*OB + b)*8 +: 8];
      end
    end else begin
      line_d = line_q;
    end
    if (flush_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_d;
    end
  end

  // Line, tag and valid registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q  <= {BRAM_DWIDTH{1'b0}};
      tag_q   <= {EW{1'b0}};
      valid_q <= 1'b0;
    end else begin
      line_q  <= line_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/rv_iopmp_entry_bram_adapter.sv
// Bridges the narrow regmap entry-access port to a wide entry BRAM.
// Writes go straight to BRAM with byte enables (and write through the line
// buffer on a tag match); reads hit the one-line buffer or fetch the line.
// Out-of-range entries get an error response without touching BRAM.
// Ports: clk_i, rst_i (sync, active-high); bus (request/response/flush,
// slave side); bram_en_o/we_o/addr_o/din_o/be_o, bram_dout_i.
module rv_iopmp_entry_bram_adapter
  import rv_iopmp_entry_bram_adapter_pkg::*;
#(
  parameter int BRAM_DWIDTH     = 128,
  parameter int OUT_WIDTH       = 32,
  parameter int DEPTH           = 8,
  parameter int BRAM_RD_LATENCY = 1,
  localparam int WORDS = words_per_line(BRAM_DWIDTH, OUT_WIDTH),
  localparam int EW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int AW    = EW + WW,
  localparam int OB    = OUT_WIDTH / 8,
  localparam int LB    = BRAM_DWIDTH / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  rv_iopmp_entry_bram_adapter_if.slave bus,
  output logic                    bram_en_o,
  output logic                    bram_we_o,
  output logic [EW-1:0]           bram_addr_o,
  output logic [BRAM_DWIDTH-1:0]  bram_din_o,
  output logic [LB-1:0]           bram_be_o,
  input  logic [BRAM_DWIDTH-1:0]  bram_dout_i
);

  if (BRAM_DWIDTH % OUT_WIDTH != 0) begin : g_bad_width
    $error("BRAM_DWIDTH must be a multiple of OUT_WIDTH");
  end
  if (!is_pow2(WORDS)) begin : g_bad_words
    $error("BRAM_DWIDTH/OUT_WIDTH must be a power of two");
  end
  if ((BRAM_RD_LATENCY < 1) || (BRAM_RD_LATENCY > 4)) begin : g_bad_lat
    $error("BRAM_RD_LATENCY must be 1..4");
  end

  bram_adapter_state_e    state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [OUT_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   bram_en_q, bram_en_d;
  logic                   bram_we_q, bram_we_d;
  logic [EW-1:0]          bram_addr_q, bram_addr_d;
  logic [BRAM_DWIDTH-1:0] bram_din_q, bram_din_d;
  logic [LB-1:0]          bram_be_q, bram_be_d;
  logic [EW-1:0]          entry_q, entry_d;
  logic [WW-1:0]          word_q, word_d;
  logic [1:0]             wait_cnt_q, wait_cnt_d;
  logic                   flushed_q, flushed_d;

  logic [EW-1:0]          req_entry_s;
  logic [WW-1:0]          req_word_s;
  int                     req_idx_s;
  logic                   in_range_s;
  logic                   hit_s;
  logic                   flush_seen_s;
  logic [OUT_WIDTH-1:0]   dout_word_s;
  logic                   lb_wr_en_s;
  logic                   lb_fill_en_s;
  logic                   lb_fill_valid_s;
  logic                   lb_valid_s;
  logic [EW-1:0]          lb_tag_s;
  logic [OUT_WIDTH-1:0]   lb_rd_data_s;

  assign req_entry_s  = bus.req_addr[AW-1:WW];
  assign req_word_s   = bus.req_addr[WW-1:0];
  assign req_idx_s    = int'(req_word_s) & (WORDS - 1);
  assign in_range_s   = int'(req_entry_s) < DEPTH;
  // A flush in the accept cycle must force a miss, so it masks the hit.
  assign hit_s        = lb_valid_s && (lb_tag_s == req_entry_s) && !bus.flush;
  assign flush_seen_s = flushed_q || bus.flush;
  assign dout_word_s  = bram_dout_i[(int'(word_q) & (WORDS - 1))*OUT_WIDTH +: OUT_WIDTH];

  rv_iopmp_line_buf #(
    .BRAM_DWIDTH (BRAM_DWIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .EW          (EW),
    .WW          (WW)
  ) u_line_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (bus.flush),
    .wr_en_i      (lb_wr_en_s),
    .wr_tag_i     (req_entry_s),
    .wr_word_i    (req_word_s),
    .wr_data_i    (bus.req_wdata),
    .wr_be_i      (bus.req_be),
    .fill_en_i    (lb_fill_en_s),
    .fill_valid_i (lb_fill_valid_s),
    .fill_tag_i   (entry_q),
    .fill_data_i  (bram_dout_i),
    .rd_word_i    (req_word_s),
    .valid_o      (lb_valid_s),
    .tag_o        (lb_tag_s),
    .rd_data_o    (lb_rd_data_s)
  );

  // Next-state and next-output logic; every response and BRAM strobe is a
  // one-cycle pulse computed here and registered below.
  always_comb begin
    state_d         = state_q;
    ready_d         = ready_q;
    rsp_valid_d     = 1'b0;
    rsp_rdata_d     = {OUT_WIDTH{1'b0}};
    rsp_err_d       = 1'b0;
    bram_en_d       = 1'b0;
    bram_we_d       = 1'b0;
    bram_addr_d     = bram_addr_q;
    bram_din_d      = bram_din_q;
    bram_be_d       = {LB{1'b0}};
    entry_d         = entry_q;
    word_d          = word_q;
    wait_cnt_d      = wait_cnt_q;
    flushed_d       = flushed_q;
    lb_wr_en_s      = 1'b0;
    lb_fill_en_s    = 1'b0;
    lb_fill_valid_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ready_q) begin
          // Returning from a read response: reopen the port.
          ready_d = 1'b1;
        end else if (bus.req_valid) begin
          ready_d   = 1'b0;
          entry_d   = req_entry_s;
          word_d    = req_word_s;
          flushed_d = 1'b0;
          if (!in_range_s) begin
            state_d     = ST_ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (bus.req_we) begin
            state_d     = ST_WRITE;
            bram_en_d   = 1'b1;
            bram_we_d   = 1'b1;
            bram_addr_d = req_entry_s;
            bram_din_d  = {WORDS{bus.req_wdata}};
            for (int w = 0; w < WORDS; w++) begin
              bram_be_d[w*OB +: OB] = (w == req_idx_s) ? bus.req_be : {OB{1'b0}};
            end
            rsp_valid_d = 1'b1;
            lb_wr_en_s  = 1'b1;
          end else if (hit_s) begin
            state_d     = ST_HIT;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = lb_rd_data_s;
          end else begin
            state_d     = ST_RD_ISSUE;
            bram_en_d   = 1'b1;
            bram_addr_d = req_entry_s;
          end
        end else begin
          ready_d = ready_q;
        end
      end
      ST_WRITE, ST_HIT, ST_ERR: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      ST_RD_ISSUE: begin
        state_d    = ST_RD_WAIT;
        wait_cnt_d = 2'(BRAM_RD_LATENCY - 1);
        flushed_d  = flush_seen_s;
      end
      ST_RD_WAIT: begin
        flushed_d = flush_seen_s;
        if (wait_cnt_q == 2'd0) begin
          // Last wait cycle: bram_dout_i holds the line now.
          state_d         = ST_IDLE;
          rsp_valid_d     = 1'b1;
          rsp_rdata_d     = dout_word_s;
          lb_fill_en_s    = 1'b1;
          lb_fill_valid_s = !flush_seen_s;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {OUT_WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= {EW{1'b0}};
      bram_din_q  <= {BRAM_DWIDTH{1'b0}};
      bram_be_q   <= {LB{1'b0}};
      entry_q     <= {EW{1'b0}};
      word_q      <= {WW{1'b0}};
      wait_cnt_q  <= 2'd0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      bram_be_q   <= bram_be_d;
      entry_q     <= entry_d;
      word_q      <= word_d;
      wait_cnt_q  <= wait_cnt_d;
      flushed_q   <= flushed_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bram_en_o     = bram_en_q;
  assign bram_we_o     = bram_we_q;
  assign bram_addr_o   = bram_addr_q;
  assign bram_din_o    = bram_din_q;
  assign bram_be_o     = bram_be_q;

endmodule

// File: tb/tb_rv_iopmp_entry_bram_adapter.sv
// Directed bench for rv_iopmp_entry_bram_adapter.
// DUT A: defaults (DEPTH 8, read latency 1). DUT B: DEPTH 6, read latency 3.
// Each DUT has its own behavioural BRAM preloaded with word w of entry e
// equal to 0xA0000000 | e<<8 | w.
module tb_rv_iopmp_entry_bram_adapter;

  logic clk;
  logic rst;
  logic sel;
  logic req_valid;
  logic req_we;
  logic [4:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0] req_be;
  logic flush;

  int n_vec;
  int n_err;

  rv_iopmp_entry_bram_adapter_if #(.AW(5), .OUT_WIDTH(32)) if_a ();
  rv_iopmp_entry_bram_adapter_if #(.AW(5), .OUT_WIDTH(32)) if_b ();

  assign if_a.req_valid = req_valid & (sel == 1'b0);
  assign if_b.req_valid = req_valid & (sel == 1'b1);
  assign if_a.flush     = flush & (sel == 1'b0);
  assign if_b.flush     = flush & (sel == 1'b1);
  assign if_a.req_we    = req_we;
  assign if_b.req_we    = req_we;
  assign if_a.req_addr  = req_addr;
  assign if_b.req_addr  = req_addr;
  assign if_a.req_wdata = req_wdata;
  assign if_b.req_wdata = req_wdata;
  assign if_a.req_be    = req_be;
  assign if_b.req_be    = req_be;

  logic         en_a, we_a, en_b, we_b;
  logic [2:0]   addr_a, addr_b;
  logic [127:0] din_a, din_b, dout_a, dout_b;
  logic [15:0]  be_a, be_b;

  rv_iopmp_entry_bram_adapter u_dut_a (
    .clk_i (clk), .rst_i (rst), .bus (if_a),
    .bram_en_o (en_a), .bram_we_o (we_a), .bram_addr_o (addr_a),
    .bram_din_o (din_a), .bram_be_o (be_a), .bram_dout_i (dout_a)
  );

  rv_iopmp_entry_bram_adapter #(.DEPTH(6), .BRAM_RD_LATENCY(3)) u_dut_b (
    .clk_i (clk), .rst_i (rst), .bus (if_b),
    .bram_en_o (en_b), .bram_we_o (we_b), .bram_addr_o (addr_b),
    .bram_din_o (din_b), .bram_be_o (be_b), .bram_dout_i (dout_b)
  );

  // Behavioural BRAMs
  logic [127:0] mem_a [8];
  logic [127:0] mem_b [8];
  logic [127:0] pb0, pb1, pb2;

  always @(posedge clk) begin
    if (en_a) begin
      if (we_a) begin
        for (int b = 0; b < 16; b++) if (be_a[b]) mem_a[addr_a][b*8 +: 8] <= din_a[b*8 +: 8];
      end else begin
        dout_a <= mem_a[addr_a];
      end
    end
  end

  always @(posedge clk) begin
    if (en_b) begin
      if (we_b) begin
        for (int b = 0; b < 16; b++) if (be_b[b]) mem_b[addr_b][b*8 +: 8] <= din_b[b*8 +: 8];
      end else begin
        pb0 <= mem_b[addr_b];
      end
    end
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign dout_b = pb2;

  // Observation view of the selected DUT
  logic         o_ready, o_valid, o_err, o_en, o_we;
  logic [31:0]  o_rdata;
  logic [2:0]   o_addr;
  logic [127:0] o_din;
  logic [15:0]  o_be;

  always_comb begin
    if (sel == 1'b0) begin
      o_ready = if_a.req_ready; o_valid = if_a.rsp_valid; o_err = if_a.rsp_err;
      o_rdata = if_a.rsp_rdata; o_en = en_a; o_we = we_a; o_addr = addr_a;
      o_din = din_a; o_be = be_a;
    end else begin
      o_ready = if_b.req_ready; o_valid = if_b.rsp_valid; o_err = if_b.rsp_err;
      o_rdata = if_b.rsp_rdata; o_en = en_b; o_we = we_b; o_addr = addr_b;
      o_din = din_b; o_be = be_b;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Results of the last request
  int           r_lat, r_nrsp, r_nen, r_nwe;
  logic [31:0]  r_rdata;
  logic         r_err, r_rdy1, r_rdy_rst;
  logic [2:0]   r_addr;
  logic [127:0] r_din;
  logic [15:0]  r_be;

  // Issue one request; observe 12 cycles. flush_k/rst_k assert flush/reset
  // during cycle T+k (0 = never); fl0 asserts flush in the accept cycle.
  task automatic run_req(input logic s, input logic we, input int entry, input int word,
                         input logic [31:0] wd, input logic [3:0] be, input logic fl0,
                         input int flush_k, input int rst_k);
    int k;
    sel = s;
    @(negedge clk);
    k = 0;
    while (!o_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("ready_wait", o_ready, 1'b1);
    req_we = we; req_addr = 5'(entry * 4 + word); req_wdata = wd; req_be = be;
    flush = fl0; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; flush = 1'b0;
    r_lat = 0; r_nrsp = 0; r_nen = 0; r_nwe = 0; r_rdata = 32'h0; r_err = 1'b0;
    r_addr = 3'd0; r_din = 128'h0; r_be = 16'h0; r_rdy1 = 1'b0; r_rdy_rst = 1'b0;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) r_rdy1 = o_ready;
      if (k == rst_k + 1) r_rdy_rst = o_ready;
      if (o_en) begin
        if (r_nen == 0) begin r_addr = o_addr; r_din = o_din; r_be = o_be; end
        r_nen++;
        if (o_we) r_nwe++;
      end
      if (o_valid) begin
        if (r_nrsp == 0) begin r_lat = k; r_rdata = o_rdata; r_err = o_err; end
        r_nrsp++;
      end
      flush = (k == flush_k);
      rst = (k == rst_k);
    end
    flush = 1'b0;
    rst = 1'b0;
  endtask

  task automatic pulse_flush(input logic s);
    sel = s;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic check_read(input string tag, input int lat, input int nen, input logic [31:0] d);
    check_eq({tag, "_lat"}, r_lat, lat);
    check_eq({tag, "_nen"}, r_nen, nen);
    check_eq({tag, "_rdata"}, r_rdata, d);
    check_eq({tag, "_nrsp"}, r_nrsp, 1);
  endtask

  logic [31:0] exp_w [4];

  initial begin
    n_vec = 0; n_err = 0;
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 5'd0;
    req_wdata = 32'h0; req_be = 4'h0; flush = 1'b0; rst = 1'b1;
    pb0 = 128'h0; pb1 = 128'h0; pb2 = 128'h0; dout_a = 128'h0;
    for (int e = 0; e < 8; e++) begin
      for (int w = 0; w < 4; w++) begin
        mem_a[e][w*32 +: 32] = 32'hA000_0000 | 32'(e << 8) | 32'(w);
        mem_b[e][w*32 +: 32] = 32'hA000_0000 | 32'(e << 8) | 32'(w);
      end
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_ready", o_ready, 1'b1);
    check_eq("rst_rsp_valid", o_valid, 1'b0);
    check_eq("rst_rdata", o_rdata, 32'h0);
    check_eq("rst_err", o_err, 1'b0);
    check_eq("rst_bram_en", o_en, 1'b0);
    check_eq("rst_bram_we", o_we, 1'b0);
    check_eq("rst_bram_be", o_be, 16'h0);
    check_eq("rst_bram_addr", o_addr, 3'd0);
    check_eq("rst_bram_din", o_din, 128'h0);

    // A: write entry 3 word 2
    run_req(1'b0, 1'b1, 3, 2, 32'hDEADBEEF, 4'hF, 1'b0, 0, 0);
    check_eq("wr_lat", r_lat, 1);
    check_eq("wr_ready_drop", r_rdy1, 1'b0);
    check_eq("wr_nen", r_nen, 1);
    check_eq("wr_nwe", r_nwe, 1);
    check_eq("wr_addr", r_addr, 3'd3);
    check_eq("wr_be", r_be, 16'h0F00);
    check_eq("wr_din", r_din, {4{32'hDEADBEEF}});
    check_eq("wr_rdata", r_rdata, 32'h0);
    check_eq("wr_err", r_err, 1'b0);

    // A: read it back (miss)
    run_req(1'b0, 1'b0, 3, 2, 32'h0, 4'h0, 1'b0, 0, 0);
    check_read("rd_back", 3, 1, 32'hDEADBEEF);
    check_eq("rd_back_nwe", r_nwe, 0);
    check_eq("rd_back_be", r_be, 16'h0);
    check_eq("rd_back_addr", r_addr, 3'd3);

    // A: words 0..3 after flush: one miss then hits
    pulse_flush(1'b0);
    exp_w[0] = 32'hA000_0300; exp_w[1] = 32'hA000_0301;
    exp_w[2] = 32'hDEADBEEF;  exp_w[3] = 32'hA000_0303;
    for (int w = 0; w < 4; w++) begin
      run_req(1'b0, 1'b0, 3, w, 32'h0, 4'h0, 1'b0, 0, 0);
      check_read($sformatf("seq_w%0d", w), (w == 0) ? 3 : 1, (w == 0) ? 1 : 0, exp_w[w]);
    end

    // A: byte write-through into the buffered entry
    run_req(1'b0, 1'b1, 3, 1, 32'h0000_00AA, 4'h1, 1'b0, 0, 0);
    check_eq("bwr_be", r_be, 16'h0010);
    check_eq("bwr_lat", r_lat, 1);
    run_req(1'b0, 1'b0, 3, 1, 32'h0, 4'h0, 1'b0, 0, 0);
    check_read("bwr_hit", 1, 0, 32'hA000_03AA);

    // A: flush with the accept forces a miss; BRAM holds the merged word
    run_req(1'b0, 1'b0, 3, 1, 32'h0, 4'h0, 1'b1, 0, 0);
    check_read("fl_accept", 3, 1, 32'hA000_03AA);

    // B: out-of-range read and write
    run_req(1'b1, 1'b0, 7, 0, 32'h0, 4'h0, 1'b0, 0, 0);
    check_eq("oor_rd_err", r_err, 1'b1);
    check_read("oor_rd", 1, 0, 32'h0);
    run_req(1'b1, 1'b1, 6, 0, 32'h1234_5678, 4'hF, 1'b0, 0, 0);
    check_eq("oor_wr_err", r_err, 1'b1);
    check_eq("oor_wr_nwe", r_nwe, 0);
    check_read("oor_wr", 1, 0, 32'h0);

    // B: last valid entry, latency 3
    run_req(1'b1, 1'b0, 5, 3, 32'h0, 4'h0, 1'b0, 0, 0);
    check_eq("b_last_err", r_err, 1'b0);
    check_read("b_last", 5, 1, 32'hA000_0503);

    // B: flush during RD_WAIT
    run_req(1'b1, 1'b0, 2, 1, 32'h0, 4'h0, 1'b0, 3, 0);
    check_read("fl_wait", 5, 1, 32'hA000_0201);
    run_req(1'b1, 1'b0, 2, 1, 32'h0, 4'h0, 1'b0, 0, 0);
    check_read("fl_reread", 5, 1, 32'hA000_0201);
    run_req(1'b1, 1'b0, 2, 0, 32'h0, 4'h0, 1'b0, 0, 0);
    check_read("fl_then_hit", 1, 0, 32'hA000_0200);

    // B: reset during RD_WAIT aborts the read
    run_req(1'b1, 1'b0, 4, 0, 32'h0, 4'h0, 1'b0, 0, 2);
    check_eq("rst_abort_nrsp", r_nrsp, 0);
    check_eq("rst_abort_ready", r_rdy_rst, 1'b1);
    run_req(1'b1, 1'b0, 2, 0, 32'h0, 4'h0, 1'b0, 0, 0);
    check_read("rst_b_miss", 5, 1, 32'hA000_0200);
    run_req(1'b0, 1'b0, 3, 1, 32'h0, 4'h0, 1'b0, 0, 0);
    check_read("rst_a_miss", 3, 1, 32'hA000_03AA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_iopmp_entry_bram_adapter.md
Name: rv_iopmp_entry_bram_adapter

Overview:
Parametrised successor of the IOPMP 128-to-32 BRAM width converter: bridges the narrow regmap entry-access port to a wide entry BRAM of arbitrary data width, depth and read latency.
Adds native byte-enable writes, a one-line read buffer so consecutive word reads of the same entry avoid BRAM accesses, an explicit flush, and an error response for out-of-range entries.
Sits between rv_iopmp_regmap and the entry BRAM inside the regmap wrapper.

Parameters:
BRAM_DWIDTH, 128, BRAM line width in bits; integer multiple of OUT_WIDTH.
OUT_WIDTH, 32, register-side word width in bits; multiple of 8.
DEPTH, 8, number of BRAM lines (entries); need not be a power of two.
BRAM_RD_LATENCY, 1, BRAM read latency in cycles; 1..4.
Derived: WORDS = BRAM_DWIDTH/OUT_WIDTH, a power of two. EW = max(1,$clog2(DEPTH)). WW = max(1,$clog2(WORDS)). AW = EW+WW.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  adapter can accept a request
req_we_i  in  1  1 = write, 0 = read
req_addr_i  in  AW  {entry index [AW-1:WW], word index [WW-1:0]}
req_wdata_i  in  OUT_WIDTH  write data
req_be_i  in  OUT_WIDTH/8  write byte enables
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  OUT_WIDTH  read data (0 for writes and errors)
rsp_err_o  out  1  entry index >= DEPTH
flush_i  in  1  invalidate line buffer
bram_en_o  out  1  BRAM enable
bram_we_o  out  1  BRAM write enable
bram_addr_o  out  EW  BRAM line address
bram_din_o  out  BRAM_DWIDTH  BRAM write data
bram_be_o  out  BRAM_DWIDTH/8  BRAM byte enables
bram_dout_i  in  BRAM_DWIDTH  BRAM read data

Behaviour:
- Single clock clk_i. Reset is synchronous and active-high on rst_i. All outputs are registered.
- Reset values: req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; all bram_* = 0; line-buffer valid=0; FSM=IDLE.
- Handshake:
  - A request is accepted in cycle T when req_valid_i && req_ready_o.
  - req_ready_o=1 only in IDLE; it drops in T+1 and rises again in the cycle after rsp_valid_o.
  - There is no response backpressure. Exactly one rsp_valid_o pulse per accepted request.
- FSM states: IDLE, WRITE, HIT, RD_ISSUE, RD_WAIT, ERR.
- Out-of-range (entry >= DEPTH): IDLE->ERR. No BRAM activity. In T+1: rsp_valid=1, rsp_err=1, rdata=0.
- Write: IDLE->WRITE. In T+1:
  - bram_en=bram_we=1, bram_addr=entry.
  - bram_din = wdata replicated into every word lane.
  - bram_be = req_be placed at byte lane word*OUT_WIDTH/8, all other bits 0.
  - rsp_valid=1, rdata=0.
  - If the line buffer holds this entry, the enabled bytes are updated in the buffer (write-through). The buffer is not invalidated.
- Read hit (buffer valid, tag==entry, no flush_i in T): IDLE->HIT. In T+1: rsp_valid=1, rdata = buffer word[word]. No BRAM access.
- Read miss: IDLE->RD_ISSUE.
  - In T+1: bram_en=1, we=0, be=0.
  - RD_WAIT lasts BRAM_RD_LATENCY cycles. bram_dout_i is sampled in cycle T+1+BRAM_RD_LATENCY and written to the buffer with the tag set.
  - In T+2+BRAM_RD_LATENCY: rsp_valid=1, rdata = selected word.
- bram_en/we/be are asserted for exactly one cycle per access.
- Flush:
  - flush_i clears buffer valid on the next edge.
  - flush_i in the same cycle as a read accept forces a miss.
  - flush_i during RD_ISSUE/RD_WAIT: the read still completes and responds, but the captured line is not marked valid.
- Reset asserted mid-operation aborts at the next edge:
  - Outputs return to reset values.
  - No response is issued for the aborted request.
  - A pending BRAM read is discarded.
- Word select is purely by index; no arithmetic overflow is possible because WORDS is a power of two.

Decomposition:
- rv_iopmp_pkg gains bram_adapter_state_e (the FSM enum) and the function words_per_line(bram_dw, out_dw).
- One sub-module: rv_iopmp_line_buf. It holds the line register, tag, valid, per-byte write-through update and word select.
- FSM and BRAM drive logic stay in the top module.
- Elaboration-time assertions: BRAM_DWIDTH % OUT_WIDTH == 0; WORDS is a power of two; 1 <= BRAM_RD_LATENCY <= 4.

Test Plan:
- Defaults. Write entry 3 word 2, data 0xDEADBEEF, be 0xF -> T+1: bram_addr=3, bram_be=0x0F00, din lane 2 = 0xDEADBEEF, rsp_valid. Read back -> miss, rsp_valid at T+3, rdata 0xDEADBEEF.
- Read entry 3 words 0,1,2,3 back-to-back -> first is a miss (latency 3). Remaining three are hits (rsp at T+1) with no bram_en pulses.
- Buffered entry 3. Write word 1, data 0x000000AA, be 0x1 -> subsequent hit read of word 1 returns the old value with the low byte replaced by 0xAA; bram_be=0x0010.
- DEPTH=6. Read entry 7 -> rsp_err=1, rdata=0, no bram_en. Write entry 6 -> rsp_err=1, no bram_we.
- BRAM_RD_LATENCY=3. Assert flush_i during RD_WAIT -> rsp at T+5 with correct data. An immediate re-read of the same entry misses again (bram_en pulses).
- Assert rst_i in the RD_WAIT cycle -> no rsp_valid. Next cycle req_ready=1, buffer invalid, and the next read misses.
